// File: rtl/fetch_if.sv
// Fetch-side bus: PC request, instruction ROM and downstream instruction handshake.
// master = fetch_ctrl, slave = environment (PC, ROM, decode).
interface fetch_if #(
  parameter int D = 12,
  parameter int W = 9
);
  logic         start;
  logic [D-1:0] prog_ctr;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_data;
  logic         flag;
  logic [W-1:0] instr_out;
  logic         instr_valid;
  logic         instr_ready;
  logic         req;
  logic         reljump_en;
  logic [D-1:0] offset;
  logic         done;

  modport master (
    input  start, prog_ctr, imem_data, flag, instr_ready,
    output imem_addr, instr_out, instr_valid, req, reljump_en, offset, done
  );

  modport slave (
    output start, prog_ctr, imem_data, flag, instr_ready,
    input  imem_addr, instr_out, instr_valid, req, reljump_en, offset, done
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: ROM address/data, downstream handshake, PC advance strobe.
// Optional FETCH_BRANCH_COUNT_EN adds a saturating 16-bit count of taken relative jumps.
module fetch_ctrl #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic clk,
  input  logic reset,
  fetch_if.master bus
`ifdef FETCH_BRANCH_COUNT_EN
  ,
  output logic [15:0] taken_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, HALT} state_t;

  state_t       state;
  logic [W-1:0] ir;
  logic         is_branch;
  logic         is_cond;
  logic         is_halt;
  logic         taken;
  logic         accept;
  logic [D-1:0] br_off;

  // Instruction decode of the held word
  assign is_branch = (ir[8:6] == 3'b111);
  assign is_cond   = ir[5];
  assign is_halt   = (ir == 9'h1C0);
  assign br_off    = {{(D-5){ir[4]}}, ir[4:0]};
  assign taken     = is_branch && !is_halt && (!is_cond || bus.flag);

  // ROM is addressed straight from the PC; the ADDR cycle just gives it an edge to sample
  assign bus.imem_addr   = bus.prog_ctr;
  assign bus.instr_out   = ir;
  assign bus.instr_valid = (state == HOLD);
  assign bus.done        = (state == HALT);

  // A halt word is consumed without advancing the PC
  assign accept         = (state == HOLD) && bus.instr_ready;
  assign bus.req        = accept && !is_halt;
  assign bus.reljump_en = bus.req && taken;
  assign bus.offset     = bus.reljump_en ? br_off : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) state <= ADDR;
        ADDR: state <= DATA;
        DATA: begin
          ir    <= bus.imem_data;
          state <= HOLD;
        end
        HOLD: if (bus.instr_ready) state <= is_halt ? HALT : ADDR;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_BRANCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      taken_cnt <= '0;
    else if (bus.reljump_en && (taken_cnt != 16'hFFFF))
      taken_cnt <= taken_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC + synchronous ROM environment, transaction-level reference model
// checked every cycle, plus directed literal expectations from the fetch scenarios.
module tb_fetch_ctrl;
  localparam int D = 12;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_if #(.D(D), .W(W)) bus();
`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] taken_cnt;
`endif

  fetch_ctrl #(.D(D), .W(W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_BRANCH_COUNT_EN
    ,
    .taken_cnt(taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] rom [0:(1<<D)-1];

  // Environment: PC register and synchronous ROM
  always @(posedge clk or posedge reset) begin
    if (reset) bus.prog_ctr <= '0;
    else if (bus.req) bus.prog_ctr <= bus.reljump_en ? bus.prog_ctr + bus.offset : bus.prog_ctr + 12'd1;
  end

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] sext5(input logic [4:0] v);
    return {{(D-5){v[4]}}, v};
  endfunction

  // Reference model: fetch of rom[pc] becomes visible 3 cycles after the trigger
  // (start or previous accept) and is held until accepted.
  logic [D-1:0] m_pc;
  bit           m_active;
  bit           m_halted;
  int           m_lat;

  always @(negedge clk) begin
    logic [W-1:0] w;
    logic         ev, eh, er, et;
    logic [D-1:0] eo;
    if (reset) begin
      m_pc = '0; m_active = 0; m_halted = 0; m_lat = 0;
    end else begin
      w  = rom[m_pc];
      ev = m_active && (m_lat == 0);
      eh = (w == 9'h1C0);
      er = ev && bus.instr_ready && !eh;
      et = er && (w[8:6] == 3'b111) && (!w[5] || bus.flag);
      eo = et ? sext5(w[4:0]) : '0;
      chk("m_valid", bus.instr_valid, ev);
      if (ev) chk("m_instr", bus.instr_out, w);
      chk("m_req", bus.req, er);
      chk("m_rel", bus.reljump_en, et);
      chk("m_off", bus.offset, eo);
      chk("m_done", bus.done, m_halted);
      chk("m_pc", bus.prog_ctr, m_pc);
      chk("m_addr", bus.imem_addr, bus.prog_ctr);
      if (!m_active && !m_halted) begin
        if (bus.start) begin m_active = 1; m_lat = 2; end
      end else if (ev && bus.instr_ready) begin
        if (eh) begin m_halted = 1; m_active = 0; end
        else begin m_pc = et ? m_pc + eo : m_pc + 12'd1; m_lat = 2; end
      end else if (m_lat > 0) begin
        m_lat--;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.instr_valid && n < 20);
    if (!bus.instr_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic expect_instr(input string nm, input logic [W-1:0] w, input logic r, input logic rj,
                              input logic [D-1:0] off, input logic [D-1:0] pc_next, input bit lat3);
    int n;
    wait_valid(n);
    if (lat3) chk({nm, "_lat"}, n, 3);
    chk({nm, "_instr"}, bus.instr_out, w);
    chk({nm, "_req"}, bus.req, r);
    chk({nm, "_rel"}, bus.reljump_en, rj);
    chk({nm, "_off"}, bus.offset, off);
    @(posedge clk); #1;
    chk({nm, "_pc"}, bus.prog_ctr, pc_next);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, bus.instr_valid, 0);
    chk({nm, "_req"}, bus.req, 0);
    chk({nm, "_rel"}, bus.reljump_en, 0);
    chk({nm, "_off"}, bus.offset, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_instr"}, bus.instr_out, 0);
`ifdef FETCH_BRANCH_COUNT_EN
    chk({nm, "_cnt"}, taken_cnt, 0);
`endif
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1<<D); i++) rom[i] = '0;
    rom[0] = 9'h012; rom[1] = 9'h1C3; rom[2] = 9'h1E3; rom[4] = 9'h1FE;
    rom[5] = 9'h0AA; rom[6] = 9'h1E1; rom[7] = 9'h1C2; rom[9] = 9'h1C0;
    bus.start = 1'b0; bus.flag = 1'b0; bus.instr_ready = 1'b1;

    // Run 1: flag low throughout
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    @(posedge clk); #1 reset = 1'b0;
    pulse_start();
    expect_instr("i0", 9'h012, 1, 0, 12'h000, 12'd1, 1);
    expect_instr("i1", 9'h1C3, 1, 1, 12'h003, 12'd4, 1);
    expect_instr("i4", 9'h1FE, 1, 0, 12'h000, 12'd5, 1);
    bus.instr_ready = 1'b0;
    wait_valid(n);
    chk("stall_lat", n, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_instr", bus.instr_out, 9'h0AA);
      chk("stall_req", bus.req, 0);
    end
    @(posedge clk); #1 bus.instr_ready = 1'b1;
    expect_instr("i5", 9'h0AA, 1, 0, 12'h000, 12'd6, 0);
    expect_instr("i6", 9'h1E1, 1, 0, 12'h000, 12'd7, 1);
    expect_instr("i7", 9'h1C2, 1, 1, 12'h002, 12'd9, 1);
    expect_instr("halt", 9'h1C0, 0, 0, 12'h000, 12'd9, 1);
    @(negedge clk);
    chk("halt_done", bus.done, 1);
    chk("halt_valid", bus.instr_valid, 0);
`ifdef FETCH_BRANCH_COUNT_EN
    chk("cnt_run1", taken_cnt, 2);
`endif
    pulse_start();
    pulse_start();
    repeat (4) @(negedge clk);
    chk("halt_stay", bus.done, 1);
    chk("halt_pc", bus.prog_ctr, 9);
    chk("halt_noreq", bus.req, 0);

    // Run 2: flag high, reset mid-HOLD
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst1");
    @(posedge clk); #1 reset = 1'b0; bus.flag = 1'b1;
    pulse_start();
    expect_instr("r0", 9'h012, 1, 0, 12'h000, 12'd1, 1);
    expect_instr("r1", 9'h1C3, 1, 1, 12'h003, 12'd4, 1);
    expect_instr("r4", 9'h1FE, 1, 1, 12'hFFE, 12'd2, 1);
    expect_instr("r2", 9'h1E3, 1, 1, 12'h003, 12'd5, 1);
    expect_instr("r5", 9'h0AA, 1, 0, 12'h000, 12'd6, 1);
    wait_valid(n);
    chk("r6_req", bus.req, 1);
    chk("r6_rel", bus.reljump_en, 1);
    chk("r6_off", bus.offset, 12'h001);
`ifdef FETCH_BRANCH_COUNT_EN
    chk("cnt_run2", taken_cnt, 3);
`endif
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async");
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_valid", bus.instr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that drives the program counter's request side. Presents the current program counter to a synchronous instruction ROM and captures the returned word. Hands the word downstream with a valid/ready handshake. On each accepted instruction it issues a one-cycle `req` to the PC, with `reljump_en`/`offset` decoded from relative-branch instructions. It stops permanently on a halt word.

## Interface
- `D`, 12, program-counter / instruction-address width
- `W`, 9, instruction width
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: begin fetching from IDLE
- `prog_ctr` in D: current PC value
- `imem_addr` out D: ROM address; continuous copy of `prog_ctr`
- `imem_data` in W: ROM read data, valid one cycle after address sampled
- `flag` in 1: branch condition from datapath
- `instr_out` out W: captured instruction register
- `instr_valid` out 1: `instr_out` holds an unconsumed instruction
- `instr_ready` in 1: downstream accepts `instr_out`
- `req` out 1: PC advance strobe
- `reljump_en` out 1: relative jump taken this `req`
- `offset` out D: sign-extended jump offset
- `done` out 1: halt reached

## Operation
- Decode of instruction register `ir`:
  - branch = `ir[8:6]==3'b111`
  - cond = `ir[5]`
  - `offset = sign-extend(ir[4:0])` to D bits
  - halt = `ir==9'h1C0` (branch, unconditional, zero offset)
- Taken = branch && !halt && (cond==0 || flag).
- States: IDLE, ADDR, DATA, HOLD, HALT.
  - IDLE: wait; `start`=1 → ADDR.
  - ADDR: ROM samples `imem_addr` at edge → DATA.
  - DATA: `ir <= imem_data` at edge → HOLD.
  - HOLD: `instr_valid`=1.
    - `instr_ready`=1 and not halt → ADDR.
    - `instr_ready`=1 and halt → HALT.
    - Else stay in HOLD; `ir` is stable.
  - HALT: `done`=1; `instr_valid`=0; `req` never asserted. Leaves only via `reset`; `start` ignored.
- `req` = HOLD && `instr_ready` && !halt (combinational, one cycle per instruction).
- `reljump_en` = `req` && taken.
- `offset` = decoded offset when `reljump_en`, else 0.
- `flag` is sampled only in the handshake cycle.
- Offset arithmetic is the PC's job; this block only sign-extends. Wrap-around past 2^D−1 is the PC's modulo behaviour.
- `start` while not in IDLE: ignored.

## Timing
- Reset values:
  - state IDLE, `ir`=0
  - `instr_valid`=0, `req`=0, `reljump_en`=0, `offset`=0, `done`=0
  - `instr_out`=0
- `reset` asserted mid-operation forces IDLE asynchronously; `req`/`instr_valid` drop the same instant.
- Throughput: 3 cycles per instruction with `instr_ready` held high (ADDR, DATA, HOLD).
- Start → first `instr_valid`: `start` seen in IDLE at edge 0; ADDR cycle 1; DATA cycle 2; `instr_valid` high in cycle 3.
- PC updates on the edge that ends the `req` cycle. The next ADDR cycle sees the new `prog_ctr`.
- Downstream backpressure: arbitrary stall in HOLD; no instruction lost or duplicated.

## Configuration
- `FETCH_BRANCH_COUNT_EN` defined:
  - Adds output `taken_cnt` (16 bits).
  - Increments on every cycle with `reljump_en`=1.
  - Saturates at 16'hFFFF.
  - Cleared by `reset`.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, ROM[0]=9'h012, `start` pulse, `instr_ready`=1:
  - `instr_valid` in cycle 3 with `instr_out`=9'h012
  - `req`=1, `reljump_en`=0 in that cycle
  - PC becomes 1
- ROM[1]=9'h1C3 (uncond, +3): `reljump_en`=1, `offset`=12'h003, next fetch at 4.
- ROM[4]=9'h1FE (cond, −2):
  - `flag`=0 → `reljump_en`=0, PC=5.
  - Rerun with `flag`=1 → `offset`=12'hFFE, PC=2.
- Hold `instr_ready`=0 for 5 cycles in HOLD:
  - `instr_valid` stays 1, `instr_out` stable, `req`=0 throughout.
  - One `req` when `ready` rises.
- ROM word 9'h1C0 accepted:
  - No `req`; `done`=1 next cycle and stays.
  - `start` pulses ignored until `reset`.
- Assert `reset` mid-HOLD with `instr_ready`=1:
  - `req`/`instr_valid` fall immediately; state IDLE.
  - With macro: `taken_cnt`=0.
